// File: rtl/mul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_unit
// Purpose  : Iterative shift-add RV32M multiplier driving an external adder.
// Revision : 1.0  initial release
// ============================================================================
module mul_seq_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_add_a,
    output logic [XLEN-1:0] o_add_b,
    output logic            o_add_cin,
    input  logic [XLEN-1:0] i_add_sum,
    input  logic            i_add_cout
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_CORR_A = 3'd2,
        S_CORR_B = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;

    assign w_accept   = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_a_signed = (op_q == 2'b01) || (op_q == 2'b10);
    assign w_b_signed = (op_q == 2'b01);

    assign o_busy   = (state_q == S_MUL) || (state_q == S_CORR_A) || (state_q == S_CORR_B);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = res_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_d     = res_q;
        o_add_a   = '0;
        o_add_b   = '0;
        o_add_cin = 1'b0;

        case (state_q)
            S_MUL: begin
                // Add a when the current multiplier bit is set, then shift the
                // 2*XLEN accumulator right by one, carry-out entering the top.
                o_add_a = acc_q;
                o_add_b = lo_q[0] ? a_q : '0;
                acc_d   = {i_add_cout, i_add_sum[XLEN-1:1]};
                lo_d    = {i_add_sum[0], lo_q[XLEN-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = S_CORR_A;
                end
            end
            S_CORR_A: begin
                o_add_a = acc_q;
                if (w_a_signed && a_q[XLEN-1]) begin
                    o_add_b   = ~b_q;
                    o_add_cin = 1'b1;
                    acc_d     = i_add_sum;
                end
                state_d = S_CORR_B;
            end
            S_CORR_B: begin
                o_add_a = acc_q;
                if (w_b_signed && b_q[XLEN-1]) begin
                    o_add_b   = ~a_q;
                    o_add_cin = 1'b1;
                    acc_d     = i_add_sum;
                end
                // The high word must include this cycle's correction.
                res_d   = (op_q == 2'b00) ? lo_q : acc_d;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept) begin
            a_d     = i_rs1;
            b_d     = i_rs2;
            op_d    = i_op;
            lo_d    = i_rs2;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_unit
// Purpose  : Directed self-checking bench for mul_seq_unit with adder model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq_unit;

    localparam int XLEN = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_start;
    logic [1:0]      i_op;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic [XLEN-1:0] o_add_a;
    logic [XLEN-1:0] o_add_b;
    logic            o_add_cin;
    logic [XLEN-1:0] w_add_sum;
    logic            w_add_cout;

    int total;
    int bad;

    logic [XLEN-1:0] rec_b   [0:63];
    logic            rec_cin [0:63];

    // Stand-in for the shared carry-lookahead adder.
    assign {w_add_cout, w_add_sum} = {1'b0, o_add_a} + {1'b0, o_add_b} + {{XLEN{1'b0}}, o_add_cin};

    mul_seq_unit #(.XLEN(XLEN)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_add_a    (o_add_a),
        .o_add_b    (o_add_b),
        .o_add_cin  (o_add_cin),
        .i_add_sum  (w_add_sum),
        .i_add_cout (w_add_cout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Assert start, wait for o_valid (bounded); lat counts edges after accept.
    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                          output int lat);
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start    = 1'b0;
        lat        = 0;
        rec_b[0]   = o_add_b;
        rec_cin[0] = o_add_cin;
        while (!o_valid && lat < 60) begin
            @(posedge i_clk);
            #1;
            lat++;
            rec_b[lat]   = o_add_b;
            rec_cin[lat] = o_add_cin;
        end
        res = o_result;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_op    = 2'b00;
        i_rs1   = '0;
        i_rs2   = '0;
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if ({o_busy, o_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags busy/valid=%b expected 00", {o_busy, o_valid});
        end
        total++;
        if ({o_result, o_add_a, o_add_b, o_add_cin} !== '0) begin
            bad++;
            $display("FAIL reset_data result=%h add_a=%h add_b=%h cin=%b expected all 0",
                     o_result, o_add_a, o_add_b, o_add_cin);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_unsigned();
        logic [XLEN-1:0] res;
        int lat;
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        total++;
        if (res !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL mulhu_ones got=%h expected=%h", res, 32'hFFFF_FFFE);
        end
        total++;
        if (lat !== 34) begin
            bad++;
            $display("FAIL mulhu_latency got=%0d expected=34", lat);
        end
        @(posedge i_clk);
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse_width got=%b expected=0", o_valid);
        end
        total++;
        if (o_result !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL result_hold got=%h expected=%h", o_result, 32'hFFFF_FFFE);
        end
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        total++;
        if (res !== 32'h0000_0001) begin
            bad++;
            $display("FAIL mul_ones got=%h expected=%h", res, 32'h0000_0001);
        end
    endtask

    task automatic test_signed();
        logic [XLEN-1:0] res;
        int lat;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        total++;
        if (res !== 32'h0000_0000) begin
            bad++;
            $display("FAIL mulh_neg1 got=%h expected=%h", res, 32'h0);
        end
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        total++;
        if (res !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL mulhsu_neg1 got=%h expected=%h", res, 32'hFFFF_FFFF);
        end
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, res, lat);
        total++;
        if (res !== 32'h4000_0000) begin
            bad++;
            $display("FAIL mulh_minint got=%h expected=%h", res, 32'h4000_0000);
        end
        run_op(2'b01, 32'h0000_0007, 32'hFFFF_FFFD, res, lat);
        total++;
        if (res !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL mulh_7xm3 got=%h expected=%h", res, 32'hFFFF_FFFF);
        end
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, res, lat);
        total++;
        if (res !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL mul_7xm3 got=%h expected=%h", res, 32'hFFFF_FFEB);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int busy_low;
        i_op    = 2'b11;
        i_rs1   = 32'hFFFF_FFFF;
        i_rs2   = 32'hFFFF_FFFF;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start  = 1'b0;
        lat      = 0;
        busy_low = 0;
        while (!o_valid && lat < 60) begin
            if (!o_busy) busy_low++;
            if (lat == 10) begin
                i_op    = 2'b00;
                i_rs1   = 32'h0000_0003;
                i_rs2   = 32'h0000_0005;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(posedge i_clk);
            #1;
            lat++;
        end
        i_start = 1'b0;
        total++;
        if (busy_low !== 0) begin
            bad++;
            $display("FAIL ignore_busy low_cycles=%0d expected=0", busy_low);
        end
        total++;
        if (o_result !== 32'hFFFF_FFFE || lat !== 34) begin
            bad++;
            $display("FAIL ignore_result got=%h lat=%0d expected=%h lat=34",
                     o_result, lat, 32'hFFFF_FFFE);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] res;
        int lat;
        run_op(2'b00, 32'h0000_0006, 32'h0000_0007, res, lat);
        total++;
        if (res !== 32'h0000_002A) begin
            bad++;
            $display("FAIL b2b_first got=%h expected=%h", res, 32'h2A);
        end
        // Called while the first op sits in DONE, so this accept is back-to-back.
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
        total++;
        if (res !== 32'hFFFF_FFFE || lat !== 34) begin
            bad++;
            $display("FAIL b2b_second got=%h lat=%0d expected=%h lat=34",
                     res, lat, 32'hFFFF_FFFE);
        end
    endtask

    task automatic test_async_reset();
        logic [XLEN-1:0] res;
        int lat;
        i_op    = 2'b11;
        i_rs1   = 32'h1234_5678;
        i_rs2   = 32'hFFFF_FFFF;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (12) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_valid, o_result, o_add_a, o_add_b, o_add_cin} !== '0) begin
            bad++;
            $display("FAIL async_reset busy=%b valid=%b result=%h add_a=%h add_b=%h cin=%b expected all 0",
                     o_busy, o_valid, o_result, o_add_a, o_add_b, o_add_cin);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run_op(2'b00, 32'h0000_0003, 32'h0000_0005, res, lat);
        total++;
        if (res !== 32'h0000_000F) begin
            bad++;
            $display("FAIL post_reset_mul got=%h expected=%h", res, 32'hF);
        end
    endtask

    task automatic test_adder_port();
        logic [XLEN-1:0] res;
        int lat;
        run_op(2'b11, 32'h1234_5678, 32'h0000_0002, res, lat);
        total++;
        if (rec_b[0] !== 32'h0 || rec_b[1] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL adder_iter add_b[0]=%h add_b[1]=%h expected 00000000 12345678",
                     rec_b[0], rec_b[1]);
        end
        total++;
        if (rec_b[32] !== 32'h0 || rec_b[33] !== 32'h0 || rec_cin[32] !== 1'b0 || rec_cin[33] !== 1'b0) begin
            bad++;
            $display("FAIL adder_corr b=%h/%h cin=%b/%b expected 0/0 0/0",
                     rec_b[32], rec_b[33], rec_cin[32], rec_cin[33]);
        end
        total++;
        if (res !== 32'h0000_0000) begin
            bad++;
            $display("FAIL adder_hi got=%h expected=%h", res, 32'h0);
        end
        run_op(2'b00, 32'h1234_5678, 32'h0000_0002, res, lat);
        total++;
        if (res !== 32'h2468_ACF0) begin
            bad++;
            $display("FAIL adder_lo got=%h expected=%h", res, 32'h2468_ACF0);
        end
        @(posedge i_clk);
        #1;
        total++;
        if ({o_add_a, o_add_b, o_add_cin} !== '0) begin
            bad++;
            $display("FAIL adder_idle add_a=%h add_b=%h cin=%b expected 0",
                     o_add_a, o_add_b, o_add_cin);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_adder_port();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
